seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Armable, software-configured controller around a serial bit-pattern detector. A config handshake loads pattern, don't-care mask, target match count, overlap mode and timeout. Once started, the block shifts in qualified serial bits, counts pattern hits, and ends a run with a done pulse (target reached), a timed_out pulse (bit budget exhausted) or an abort. It sits between the register/control plane and the serial data stream of the detector datapath.

Parameters:
WIDTH, 8, pattern/mask/shift-register width in bits (>=2)
CNT_W, 8, width of target and match counter
TMO_W, 16, width of timeout bit-budget counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when cfg_valid&cfg_ready
cfg_pattern  in  WIDTH  pattern to match, MSB = oldest bit
cfg_mask  in  WIDTH  1 = compare bit, 0 = don't care
cfg_target  in  CNT_W  matches required for done; 0 = unlimited
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_timeout  in  TMO_W  max qualified bits per run; 0 = disabled
start  in  1  arm a run (IDLE only)
abort  in  1  terminate run (ARMED only)
data_valid  in  1  qualifies data
data  in  1  serial bit
busy  out  1  high in ARMED
match  out  1  one-cycle pulse per detected match
match_count  out  CNT_W  matches in current/last run
done  out  1  one-cycle pulse, target reached
timed_out  out  1  one-cycle pulse, budget exhausted

Behaviour:
- Reset (rst_n low, async): state IDLE, configured flag 0, config regs 0, shift reg 0, fill 0, bit counter 0; cfg_ready 1 (combinational from IDLE), busy 0, match 0, match_count 0, done 0, timed_out 0.
- States: IDLE, ARMED. cfg_ready = (state==IDLE); busy = (state==ARMED).
- IDLE: cfg handshake captures all cfg_* fields, sets configured=1. start with configured=1 and no handshake in that cycle -> ARMED next edge; shift reg, fill, bit counter, match_count cleared. start with configured=0 ignored. cfg handshake and start same cycle: config taken, start ignored.
- ARMED: cfg_valid ignored (cfg_ready 0). Per edge with data_valid: next_shift = {shift[WIDTH-2:0], data}; fill = min(fill+1, WIDTH); bits = bits+1.
- Hit when fill (post-increment) == WIDTH and ((next_shift ^ pattern) & mask) == 0. Mask 0 = hit on every full window.
- On hit: match pulses and match_count increments, both visible after that edge (1-cycle latency from the sampled bit). match_count saturates at all-ones. cfg_overlap=0: shift reg and fill cleared instead of loaded (next match needs WIDTH fresh bits). cfg_overlap=1: window keeps sliding.
- Target: hit that makes match_count == cfg_target (target!=0) -> done pulses with that match pulse; IDLE next edge.
- Timeout: cfg_timeout!=0 and bits (post-increment) == cfg_timeout without done -> timed_out pulses; IDLE. Done and timeout on same bit: done only.
- abort in ARMED: IDLE next edge, no done/timed_out, data on that edge discarded; match_count holds. abort has priority over data_valid. abort in IDLE ignored.
- start in ARMED ignored. data_valid=0 freezes all datapath state.
- match_count holds after run end until next start or reset; config persists across runs.
- Reset mid-run: immediate return to reset values; configured cleared.

Test Plan:
- Basic: cfg pattern 8'hD9, mask 8'hFF, target 1, overlap 0, timeout 0; start; bits 1101_1001 -> match+done on edge after 8th bit, match_count=1, busy drops next cycle.
- Overlap: pattern 8'hAA, mask 8'hFF, target 0, stream 1010101010 (10 bits): overlap=1 -> 2 matches (bits 8, 10); overlap=0 -> 1 match; match_count 2 vs 1.
- Mask: pattern 8'hD0, mask 8'hF0, target 3, overlap 0: bytes D3, 5F, DF, DA -> matches on bytes 1, 3, 4; done with third match, match_count=3.
- Timeout: pattern 8'hFF, target 1, timeout 12, stream all zeros -> timed_out on 12th qualified bit, no done, match_count 0; repeat with 1s on bits 5-12 -> done only.
- Abort/gaps: run with data_valid toggled 1-0-1 (gaps ignored), abort after 5 bits -> IDLE, no pulses; start without any prior config after reset is ignored (busy stays 0).
- Reset mid-run: deassert rst_n while ARMED with match_count=2 -> all outputs 0 immediately, cfg_ready 1, start ignored until reconfigured.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if
// Groups the config handshake, run control, serial data and status signals
// of the sequence-detector controller into a single bundle.
//   master : register/control plane + serial source (drives cfg_*, start,
//            abort, data_valid, data; observes status)
//   slave  : the controller itself
// Signals:
//   cfg_valid/cfg_ready      config handshake
//   cfg_pattern/cfg_mask     pattern to match (MSB oldest) and compare mask
//   cfg_target               matches for done (0 = unlimited)
//   cfg_overlap              1 = overlapping matches allowed
//   cfg_timeout              qualified-bit budget per run (0 = disabled)
//   start/abort              run control
//   data_valid/data          qualified serial bit
//   busy/match/match_count   run status, per-match pulse, hit counter
//   done/timed_out           run-end pulses
interface seq_detect_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_pattern;
  logic [WIDTH-1:0] cfg_mask;
  logic [CNT_W-1:0] cfg_target;
  logic             cfg_overlap;
  logic [TMO_W-1:0] cfg_timeout;
  logic             start;
  logic             abort;
  logic             data_valid;
  logic             data;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             timed_out;

  modport master (
    output cfg_valid, cfg_pattern, cfg_mask, cfg_target, cfg_overlap,
           cfg_timeout, start, abort, data_valid, data,
    input  cfg_ready, busy, match, match_count, done, timed_out
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_mask, cfg_target, cfg_overlap,
           cfg_timeout, start, abort, data_valid, data,
    output cfg_ready, busy, match, match_count, done, timed_out
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Armable controller around a serial bit-pattern detector. A config
// handshake (IDLE only) loads pattern, mask, target count, overlap mode and
// timeout. start arms a run; qualified serial bits are shifted in and hits
// counted. A run ends with done (target reached), timed_out (bit budget
// exhausted) or abort.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_detect_ctrl_if.slave (config, control, data, status)
module seq_detect_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_detect_ctrl_if.slave    bus
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  logic [0:0]        state;
  logic              configured;
  logic [WIDTH-1:0]  pattern_q;
  logic [WIDTH-1:0]  mask_q;
  logic [CNT_W-1:0]  target_q;
  logic              overlap_q;
  logic [TMO_W-1:0]  timeout_q;
  logic [WIDTH-1:0]  shift_q;
  logic [FILL_W-1:0] fill_q;
  logic [TMO_W-1:0]  bits_q;
  logic              match_q;
  logic [CNT_W-1:0]  count_q;
  logic              done_q;
  logic              timed_out_q;

  logic [WIDTH-1:0]  next_shift;
  logic [FILL_W-1:0] next_fill;
  logic [TMO_W-1:0]  next_bits;
  logic [CNT_W-1:0]  next_count;
  logic              hit;
  logic              target_hit;
  logic              budget_hit;
  logic              cfg_fire;

  assign cfg_fire = bus.cfg_valid && (state == IDLE);

  // Candidate datapath values for the bit presented this cycle. The window
  // check uses the post-shift register and post-increment fill so a hit is
  // reported on the same edge that consumes the completing bit.
  always_comb begin
    next_shift = {shift_q[WIDTH-2:0], bus.data};
    next_fill  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    next_bits  = bits_q + 1'b1;
    next_count = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;
    hit        = (next_fill == FILL_FULL) &&
                 (((next_shift ^ pattern_q) & mask_q) == '0);
    target_hit = hit && (target_q != '0) && (next_count == target_q);
    budget_hit = (timeout_q != '0) && (next_bits == timeout_q);
  end

  // Single sequential block for state, config and datapath. Pulse outputs
  // default low every cycle so each one lasts exactly one clock. In ARMED,
  // abort wins over data; done wins over timeout when both land on one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      configured  <= 1'b0;
      pattern_q   <= '0;
      mask_q      <= '0;
      target_q    <= '0;
      overlap_q   <= 1'b0;
      timeout_q   <= '0;
      shift_q     <= '0;
      fill_q      <= '0;
      bits_q      <= '0;
      match_q     <= 1'b0;
      count_q     <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            pattern_q  <= bus.cfg_pattern;
            mask_q     <= bus.cfg_mask;
            target_q   <= bus.cfg_target;
            overlap_q  <= bus.cfg_overlap;
            timeout_q  <= bus.cfg_timeout;
            configured <= 1'b1;
          end else if (bus.start && configured) begin
            state   <= ARMED;
            shift_q <= '0;
            fill_q  <= '0;
            bits_q  <= '0;
            count_q <= '0;
          end
        end
        ARMED: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.data_valid) begin
            bits_q <= next_bits;
            if (hit) begin
              match_q <= 1'b1;
              count_q <= next_count;
              // Non-overlap mode restarts the window so the next match
              // needs WIDTH fresh bits.
              if (overlap_q) begin
                shift_q <= next_shift;
                fill_q  <= next_fill;
              end else begin
                shift_q <= '0;
                fill_q  <= '0;
              end
            end else begin
              shift_q <= next_shift;
              fill_q  <= next_fill;
            end
            if (target_hit) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else if (budget_hit) begin
              timed_out_q <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready   = (state == IDLE);
  assign bus.busy        = (state == ARMED);
  assign bus.match       = match_q;
  assign bus.match_count = count_q;
  assign bus.done        = done_q;
  assign bus.timed_out   = timed_out_q;

endmodule
